// File: rtl/hv_wdg_scan_pkg.sv
// Shared types and CRC-8 helper for the watchdog register-scan sequencer.
// crc8_calc is also used by the register file's write-CRC checker.
package hv_wdg_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INTV,
    ST_REQ,
    ST_CHECK,
    ST_DONE
  } scan_state_e;

  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam logic [7:0] CRC8_INIT   = 8'hFF;
  localparam int         CRC8_DATA_W = 8;

  // Bit-serial CRC-8, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_calc(input logic [CRC8_DATA_W-1:0] data);
    logic [7:0] crc;
    logic       fb;
    crc = CRC8_INIT;
    for (int i = CRC8_DATA_W - 1; i >= 0; i--) begin
      fb  = crc[7] ^ data[i];
      crc = {crc[6:0], 1'b0};
      if (fb) crc = crc ^ CRC8_POLY;
    end
    return crc;
  endfunction

endpackage

// File: rtl/hv_wdg_scan_ctrl.sv
// Watchdog register-scan sequencer: periodically reads an address window through
// the arbiter's low-priority port, re-checks each stored CRC and logs sticky faults.
module hv_wdg_scan_ctrl
  import hv_wdg_scan_pkg::*;
#(
  parameter int                REG_AW          = 7,
  parameter int                REG_DW          = 8,
  parameter int                REG_CRC_W       = 8,
  parameter logic [REG_AW-1:0] SCAN_START_ADDR = 7'h00,
  parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h3F,
  parameter int                SCAN_INTV_W     = 16,
  parameter int                ACK_TMO_CYC     = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_scan_en,
  input  logic [SCAN_INTV_W-1:0] i_scan_intv,
  input  logic                   i_scan_err_clr,
  output logic                   o_wdg_scan_rac_rd_req,
  output logic [REG_AW-1:0]      o_wdg_scan_rac_addr,
  input  logic                   i_rac_wdg_scan_ack,
  input  logic [REG_DW-1:0]      i_rac_wdg_scan_data,
  input  logic [REG_CRC_W-1:0]   i_rac_wdg_scan_crc,
  output logic                   o_scan_busy,
  output logic                   o_scan_done,
  output logic                   o_crc_err,
  output logic                   o_tmo_err,
  output logic [REG_AW-1:0]      o_err_addr,
  output logic [7:0]             o_err_cnt
);

  localparam int             TMO_W    = $clog2(ACK_TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO_CYC - 1);

  scan_state_e            state_q, state_d;
  logic [SCAN_INTV_W-1:0] intv_cnt_q, intv_cnt_d;
  logic [REG_AW-1:0]      addr_q, addr_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   req_q, req_d;
  logic                   tmo_hit_q, tmo_hit_d;
  logic [REG_DW-1:0]      rd_data_q, rd_data_d;
  logic [REG_CRC_W-1:0]   rd_crc_q, rd_crc_d;
  logic                   crc_err_q, crc_err_d;
  logic                   tmo_err_q, tmo_err_d;
  logic [REG_AW-1:0]      err_addr_q, err_addr_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic                   crc_fault;
  logic                   tmo_fault;
  logic                   first_fault;
  logic [REG_CRC_W-1:0]   calc_crc;

  assign calc_crc = crc8_calc(rd_data_q);

  always_comb begin
    state_d    = state_q;
    intv_cnt_d = intv_cnt_q;
    addr_d     = addr_q;
    tmo_cnt_d  = tmo_cnt_q;
    req_d      = 1'b0;
    tmo_hit_d  = tmo_hit_q;
    rd_data_d  = rd_data_q;
    rd_crc_d   = rd_crc_q;
    crc_fault  = 1'b0;
    tmo_fault  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_scan_en) begin
          state_d    = ST_WAIT_INTV;
          intv_cnt_d = i_scan_intv;
        end
      end

      ST_WAIT_INTV: begin
        if (!i_scan_en) begin
          state_d = ST_IDLE;
        end else if (intv_cnt_q == '0) begin
          state_d   = ST_REQ;
          addr_d    = SCAN_START_ADDR;
          tmo_cnt_d = '0;
          req_d     = 1'b1;
        end else begin
          intv_cnt_d = intv_cnt_q - 1'b1;
        end
      end

      // Scan enable is ignored here so an issued request always closes out.
      ST_REQ: begin
        if (i_rac_wdg_scan_ack) begin
          rd_data_d = i_rac_wdg_scan_data;
          rd_crc_d  = i_rac_wdg_scan_crc;
          tmo_hit_d = 1'b0;
          state_d   = ST_CHECK;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_fault = 1'b1;
          tmo_hit_d = 1'b1;
          state_d   = ST_CHECK;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          req_d     = 1'b1;
        end
      end

      // A timed-out read passes through here only to advance; its data is stale.
      ST_CHECK: begin
        crc_fault = !tmo_hit_q && (calc_crc != rd_crc_q);
        if (!i_scan_en) begin
          state_d = ST_IDLE;
        end else if (addr_q == SCAN_END_ADDR) begin
          state_d = ST_DONE;
        end else begin
          addr_d    = addr_q + 1'b1;
          tmo_cnt_d = '0;
          req_d     = 1'b1;
          state_d   = ST_REQ;
        end
      end

      ST_DONE: begin
        if (i_scan_en) begin
          state_d    = ST_WAIT_INTV;
          intv_cnt_d = i_scan_intv;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // A clear coinciding with a fault leaves only that fault recorded.
  always_comb begin
    crc_err_d   = crc_err_q;
    tmo_err_d   = tmo_err_q;
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_cnt_q;
    first_fault = i_scan_err_clr || !(crc_err_q || tmo_err_q);

    if (i_scan_err_clr) begin
      crc_err_d  = 1'b0;
      tmo_err_d  = 1'b0;
      err_addr_d = '0;
      err_cnt_d  = '0;
    end

    if (crc_fault || tmo_fault) begin
      if (crc_fault) crc_err_d = 1'b1;
      if (tmo_fault) tmo_err_d = 1'b1;
      if (first_fault) err_addr_d = addr_q;
      if (err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      intv_cnt_q <= '0;
      addr_q     <= '0;
      tmo_cnt_q  <= '0;
      req_q      <= 1'b0;
      tmo_hit_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      intv_cnt_q <= intv_cnt_d;
      addr_q     <= addr_d;
      tmo_cnt_q  <= tmo_cnt_d;
      req_q      <= req_d;
      tmo_hit_q  <= tmo_hit_d;
      crc_err_q  <= crc_err_d;
      tmo_err_q  <= tmo_err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Captured read data is only consumed in CHECK, so it needs no reset.
  always_ff @(posedge i_clk) begin
    rd_data_q <= rd_data_d;
    rd_crc_q  <= rd_crc_d;
  end

  assign o_wdg_scan_rac_rd_req = req_q;
  assign o_wdg_scan_rac_addr   = addr_q;
  assign o_scan_busy           = (state_q == ST_REQ) || (state_q == ST_CHECK);
  assign o_scan_done           = (state_q == ST_DONE);
  assign o_crc_err             = crc_err_q;
  assign o_tmo_err             = tmo_err_q;
  assign o_err_addr            = err_addr_q;
  assign o_err_cnt             = err_cnt_q;

endmodule

// File: tb/tb_hv_wdg_scan_ctrl.sv
// Directed-plus-random bench for hv_wdg_scan_ctrl over a 4-address window,
// acting as the arbiter and checking against a pass-level reference model.
module tb_hv_wdg_scan_ctrl;

  localparam int         AW    = 7;
  localparam int         TMO   = 32;
  localparam logic [6:0] START = 7'h00;
  localparam logic [6:0] LAST  = 7'h03;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] intv;
  logic        clr;
  logic        rd_req;
  logic [6:0]  rd_addr;
  logic        ack;
  logic [7:0]  rdata;
  logic [7:0]  rcrc;
  logic        busy;
  logic        done;
  logic        crc_err;
  logic        tmo_err;
  logic [6:0]  err_addr;
  logic [7:0]  err_cnt;

  int n_vec = 0;
  int n_mis = 0;
  int done_seen = 0;

  // Reference model state
  bit         m_crc;
  bit         m_tmo;
  logic [6:0] m_addr;
  int         m_cnt;
  int         m_done;
  logic [6:0] exp_addr;

  hv_wdg_scan_ctrl #(
    .REG_AW(AW), .REG_DW(8), .REG_CRC_W(8),
    .SCAN_START_ADDR(START), .SCAN_END_ADDR(LAST),
    .SCAN_INTV_W(16), .ACK_TMO_CYC(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_scan_en(en), .i_scan_intv(intv),
    .i_scan_err_clr(clr),
    .o_wdg_scan_rac_rd_req(rd_req), .o_wdg_scan_rac_addr(rd_addr),
    .i_rac_wdg_scan_ack(ack), .i_rac_wdg_scan_data(rdata),
    .i_rac_wdg_scan_crc(rcrc),
    .o_scan_busy(busy), .o_scan_done(done),
    .o_crc_err(crc_err), .o_tmo_err(tmo_err),
    .o_err_addr(err_addr), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [7:0] ref_crc8(input logic [7:0] d);
    logic [7:0] c;
    c = 8'hFF ^ d;
    repeat (8) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_event(input bit fault, input bit is_tmo, input logic [6:0] a, input bit clr_now);
    if (clr_now) begin
      m_crc = 0; m_tmo = 0; m_addr = '0; m_cnt = 0;
    end
    if (fault) begin
      if (!m_crc && !m_tmo) m_addr = a;
      if (is_tmo) m_tmo = 1; else m_crc = 1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_crc_err"}, 32'(crc_err), 32'(m_crc));
    chk({tag, "_tmo_err"}, 32'(tmo_err), 32'(m_tmo));
    chk({tag, "_err_addr"}, 32'(err_addr), 32'(m_addr));
    chk({tag, "_err_cnt"}, 32'(err_cnt), m_cnt);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_event(0, 0, '0, 1);
    chk_flags("clr");
  endtask

  // Acts as the arbiter for one read; stall = cycles between req and ack.
  task automatic serve_read(input int stall, input bit give_ack, input logic [7:0] d,
                            input bit bad, input bit clr_with, input bit dis);
    int         waited;
    int         hi;
    logic [6:0] a;
    waited = 0;
    while (rd_req !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", 32'(rd_req), 1);
    if (rd_req !== 1'b1) return;
    chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
    chk("busy_in_req", 32'(busy), 1);
    a = exp_addr;
    if (give_ack) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (dis && i == 0) en = 1'b0;
        chk("req_hold", {24'd0, rd_req, rd_addr}, {24'd0, 1'b1, a});
      end
      ack = 1'b1; rdata = d; rcrc = ref_crc8(d) ^ (bad ? 8'h01 : 8'h00);
      @(negedge clk);
      ack = 1'b0; rdata = 8'($urandom); rcrc = 8'($urandom);
      chk("req_drop", 32'(rd_req), 0);
      clr = clr_with;
      @(negedge clk);
      clr = 1'b0;
      model_event(bad, 0, a, clr_with);
    end else begin
      hi = 1;
      while (rd_req === 1'b1 && hi <= TMO + 4) begin
        @(negedge clk);
        if (rd_req === 1'b1) hi++;
      end
      chk("tmo_req_len", hi, TMO);
      ack = 1'b1; rdata = 8'($urandom); rcrc = 8'($urandom);
      @(negedge clk);
      ack = 1'b0;
      model_event(1, 1, a, 0);
    end
    exp_addr = (exp_addr == LAST) ? START : exp_addr + 7'd1;
    chk_flags("after_read");
  endtask

  task automatic expect_done(input bit measure);
    int w;
    int g;
    w = 0;
    while (done !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk("done_pulse", 32'(done), 1);
    m_done++;
    @(negedge clk);
    chk("done_single", 32'(done), 0);
    if (measure) begin
      g = 1;
      while (rd_req !== 1'b1 && g < 200) begin
        @(negedge clk);
        g++;
      end
      chk("pass_gap_in_range", 32'((g >= int'(intv)) && (g <= int'(intv) + 2)), 1);
    end
  endtask

  task automatic run_pass(input int stall, input bit all_bad);
    for (int k = 0; k <= int'(LAST); k++)
      serve_read(stall, 1, 8'($urandom), all_bad, 0, 0);
    expect_done(0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; intv = '0; clr = 1'b0;
    ack = 1'b0; rdata = '0; rcrc = '0;
    m_crc = 0; m_tmo = 0; m_addr = '0; m_cnt = 0; m_done = 0;
    exp_addr = START;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(rd_req), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk_flags("rst");
    rst = 1'b0;

    // Clean pass, ack two cycles after request
    intv = 16'd4; en = 1'b1;
    for (int k = 0; k <= int'(LAST); k++) serve_read(2, 1, 8'($urandom), 0, 0, 0);
    expect_done(1);

    // Corrupted stored CRC at 0x02 with data 0x5A
    for (int k = 0; k <= int'(LAST); k++)
      serve_read(2, 1, (k == 2) ? 8'h5A : 8'($urandom), k == 2, 0, 0);
    expect_done(0);
    chk("crc_fault_addr", 32'(err_addr), 32'h2);
    pulse_clr();

    // Ack timeout at 0x01 with a stray late ack
    serve_read(1, 1, 8'($urandom), 0, 0, 0);
    serve_read(0, 0, 8'h00, 0, 0, 0);
    serve_read(3, 1, 8'($urandom), 0, 0, 0);
    serve_read(0, 1, 8'($urandom), 0, 0, 0);
    expect_done(0);
    chk("tmo_fault_addr", 32'(err_addr), 32'h1);

    // Long arbiter stalls up to the last accepted cycle
    serve_read(20, 1, 8'($urandom), 0, 0, 0);
    serve_read(TMO - 1, 1, 8'($urandom), 0, 0, 0);
    serve_read(0, 1, 8'($urandom), 0, 0, 0);
    serve_read(5, 1, 8'($urandom), 0, 0, 0);
    expect_done(0);
    pulse_clr();

    // Five faults, then a clear coinciding with a fault at 0x03
    run_pass(1, 1);
    serve_read(1, 1, 8'($urandom), 1, 0, 0);
    serve_read(1, 1, 8'($urandom), 0, 0, 0);
    serve_read(1, 1, 8'($urandom), 0, 0, 0);
    chk("cnt_before_clr", 32'(err_cnt), 5);
    serve_read(1, 1, 8'($urandom), 1, 1, 0);
    expect_done(0);

    // Random passes
    for (int p = 0; p < 6; p++) begin
      intv = 16'($urandom_range(0, 6));
      for (int k = 0; k <= int'(LAST); k++)
        serve_read($urandom_range(0, 12), ($urandom_range(0, 15) != 0), 8'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 0);
      expect_done(0);
    end

    // Saturating fault count
    intv = 16'd0;
    pulse_clr();
    for (int p = 0; p < 64; p++) run_pass($urandom_range(0, 3), 1);
    chk("err_cnt_sat", 32'(err_cnt), 32'hFF);

    // Disable while awaiting ack at 0x01
    pulse_clr();
    serve_read(2, 1, 8'($urandom), 0, 0, 0);
    serve_read(4, 1, 8'($urandom), 1, 0, 1);
    begin
      bit saw_req;
      saw_req = 0;
      repeat (60) begin
        @(negedge clk);
        if (rd_req !== 1'b0 || busy !== 1'b0) saw_req = 1;
      end
      chk("no_req_after_disable", 32'(saw_req), 0);
    end
    chk("done_count", done_seen, m_done);
    chk_flags("after_disable");

    // Reset clears sticky state
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_event(0, 0, '0, 1);
    chk_flags("rst2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
